reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 120 ++++++++++++
 tb/tb_reg_dump.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// reg_dump: walks a small register file through its combinational read port
// and presents each captured word on a valid/ready stream, one word per
// READ/SEND pair, pulsing done once the final word has been accepted.
module reg_dump #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW:0]   count,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW-1:0] m_addr,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    // Number of registers expressed in the width of the count port.
    localparam logic [AW:0] NREG_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] ptr;
    logic [AW:0]   remaining;
    logic [AW:0]   eff_count;
    logic          handshake;

    // A count of zero or beyond the register file size means "dump everything".
    assign eff_count = ((count == '0) || (count > NREG_CNT)) ? NREG_CNT : count;
    assign handshake = (state == SEND) && m_ready;
    assign rd_addr   = ptr;

    // State register; reset aborts any dump in progress immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the state-derived stream/status outputs.
    always_comb begin
        next_state = state;
        m_valid    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = READ;
                end
            end
            READ: begin
                next_state = SEND;
            end
            SEND: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    next_state = m_last ? DONE : READ;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Pointer/counter bookkeeping and the snapshot of the word being presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            remaining <= '0;
            m_data    <= '0;
            m_addr    <= '0;
            m_last    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= first_addr;
                        remaining <= eff_count;
                    end
                end
                READ: begin
                    m_data <= rd_data;
                    m_addr <= ptr;
                    m_last <= (remaining == (AW+1)'(1));
                end
                SEND: begin
                    if (handshake && !m_last) begin
                        ptr       <= ptr + AW'(1);
                        remaining <= remaining - (AW+1)'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: drives reg_dump against a behavioural register file and checks
// every presented word against a list of expected (address, data) pairs built
// from the register contents at the moment each dump is requested.
module tb_reg_dump;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] first_addr;
    logic [2:0] count;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] m_addr;
    logic       m_last;
    logic       busy;
    logic       done;

    logic [7:0] regs [4];

    int checks;
    int failures;

    reg_dump #(.DW(8), .AW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .count      (count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_addr     (m_addr),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    // Combinational register file read port.
    assign rd_data = regs[rd_addr];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        check_output("rst_m_valid", m_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_m_data", m_data, 0);
        check_output("rst_m_addr", m_addr, 0);
        check_output("rst_m_last", m_last, 0);
        check_output("rst_rd_addr", rd_addr, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        m_ready = 1'b0;
        #3;
        check_reset_state();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One complete dump. Entered 1 time unit after a rising edge with the DUT
    // idle; returns 1 time unit after the edge that leaves DONE.
    task automatic run_dump(input logic [1:0] fa, input logic [2:0] cnt, input int ready_pct,
                            input int stall, input bit do_write, input bit poke_start,
                            input bit poke_done);
        logic [1:0] exp_addr [$];
        logic [7:0] exp_data [$];
        int  n;
        int  idx;
        int  cyc;
        int  vcnt;
        bit  prev_hs;
        n = ((cnt == 0) || (cnt > 4)) ? 4 : int'(cnt);
        for (int i = 0; i < n; i++) begin
            int a;
            a = (int'(fa) + i) % 4;
            exp_addr.push_back(2'(a));
            exp_data.push_back(regs[a]);
        end
        start = 1'b1;
        first_addr = fa;
        count = cnt;
        m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_output("idle_busy", busy, 0);
        check_output("idle_valid", m_valid, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        idx = 0;
        cyc = 0;
        vcnt = 0;
        prev_hs = 1'b1;
        while (idx < n && cyc < 400) begin
            m_ready = ($urandom_range(0, 99) < ready_pct);
            if (idx == 0 && vcnt < stall) m_ready = 1'b0;
            if (poke_start) begin
                start = 1'($urandom_range(0, 1));
                first_addr = 2'($urandom);
                count = 3'($urandom);
            end
            if (do_write && m_valid) regs[exp_addr[idx]] = 8'hAA;
            @(negedge clk);
            check_output("run_busy", busy, 1);
            check_output("run_done", done, 0);
            check_output("valid_pattern", m_valid, prev_hs ? 0 : 1);
            if (m_valid) begin
                check_output("m_data", m_data, exp_data[idx]);
                check_output("m_addr", m_addr, exp_addr[idx]);
                check_output("m_last", m_last, (idx == n - 1) ? 1 : 0);
                vcnt++;
            end
            prev_hs = m_valid && m_ready;
            if (prev_hs) idx++;
            cyc++;
            @(posedge clk);
            #1;
        end
        check_output("words_within_budget", (cyc < 400) ? 1 : 0, 1);
        if (cyc >= 400) begin
            apply_reset();
            return;
        end
        start = poke_done;
        first_addr = 2'($urandom);
        count = 3'($urandom);
        m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_output("done_pulse", done, 1);
        check_output("done_busy", busy, 1);
        check_output("done_valid", m_valid, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        m_ready = 1'b0;
    endtask

    // Directed scenarios first, then randomized dumps.
    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start = 1'b0;
        first_addr = '0;
        count = '0;
        m_ready = 1'b0;
        regs[0] = 8'h11;
        regs[1] = 8'h22;
        regs[2] = 8'h33;
        regs[3] = 8'h44;
        #12;
        check_reset_state();
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] full dump from 0");
        run_dump(2'd0, 3'd4, 100, 0, 0, 0, 0);
        $display("[TB] wrap-around dump");
        run_dump(2'd3, 3'd2, 100, 0, 0, 0, 0);
        $display("[TB] count 0 and count 7");
        run_dump(2'd1, 3'd0, 100, 0, 0, 0, 0);
        run_dump(2'd2, 3'd7, 100, 0, 0, 0, 0);
        $display("[TB] stall with overwrite");
        run_dump(2'd1, 3'd3, 100, 5, 1, 0, 0);
        regs[1] = 8'h22;
        regs[2] = 8'h33;
        regs[3] = 8'h44;
        $display("[TB] start pokes mid-dump and in DONE");
        run_dump(2'd0, 3'd4, 70, 0, 0, 1, 1);
        run_dump(2'd2, 3'd3, 60, 0, 0, 1, 1);

        $display("[TB] reset during SEND");
        start = 1'b1;
        first_addr = 2'd0;
        count = 3'd4;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("pre_reset_valid", m_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_valid_drop", m_valid, 0);
        check_output("async_busy_drop", busy, 0);
        check_reset_state();
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        check_output("reset_hold_valid", m_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_dump(2'd2, 3'd2, 100, 0, 0, 0, 0);

        $display("[TB] randomized dumps");
        for (int t = 0; t < 25; t++) begin
            for (int r = 0; r < 4; r++) regs[r] = 8'($urandom);
            run_dump(2'($urandom), 3'($urandom), $urandom_range(30, 100),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
